receive: RTL
============

Name: receive

Overview:
- UART receiver: the receive-side counterpart of the existing `send` transmitter.
- Deserialises PHYSICAL_UART_RX (8N1, LSB first) into bytes on the PHYSICAL_CLOCK domain.
- Produces a one-cycle valid strobe per byte and error flags for consumption by chipset/top.
- Bit timing matches `send`, so one parameter value serves both ends of the link.

Parameters:
- CLKS_PER_BIT, 32'h28B0, CLK cycles per UART bit (100 MHz / 9600 baud); legal range 4 to 2^32-1.

Ports:
- CLK  input  1  system clock (PHYSICAL_CLOCK).
- RESET  input  1  asynchronous, active-low reset; top connects PHYSICAL_RESET directly.
- UART_RX  input  1  raw serial line; idle high; asynchronous to CLK.
- data  output  8  last correctly framed byte; held until the next good frame.
- valid  output  1  one-cycle pulse when `data` updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RESET=0, asynchronous):
  - data=8'h00, valid=0, frame_err=0, busy=0.
  - State=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: two flops on UART_RX produce rx_s, adding 2 cycles of latency. All FSM decisions use rx_s only.
- Counter rules:
  - cnt is 32 bits.
  - bit_idx is 3 bits and saturates at 7; it never wraps.
- IDLE:
  - rx_s==0 -> START, cnt=0.
  - Otherwise stay in IDLE.
- START:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT/2-1 (integer divide), sample rx_s:
    - 0 -> DATA, cnt=0, bit_idx=0.
    - 1 -> IDLE (glitch rejected; no flag raised).
- DATA:
  - At cnt==CLKS_PER_BIT-1: shift[bit_idx]=rx_s, cnt=0.
  - If bit_idx==7 -> STOP; else bit_idx+1.
  - Net effect: each data bit is sampled at its centre.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s:
    - 1 -> data=shift and valid=1 for exactly one cycle.
    - 0 -> frame_err=1 for exactly one cycle; data unchanged.
  - Either case -> IDLE in the same cycle.
- Line held low after a frame error (break condition): IDLE re-enters START immediately. Every subsequent frame fails its stop-bit check, so frame_err pulses once per frame time and no valid is produced.
- Back-to-back frames: leaving STOP at the centre of the stop bit leaves half a bit of margin, which is enough to catch the next start edge.
- valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: abort immediately, with no strobe on release. The FSM restarts from IDLE and waits for rx_s==0, so a partially received frame is discarded or misframed. Framing recovers after a line-idle gap.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the UART_RX falling edge, ±1 cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state sits between DATA and STOP.
  - PARITY samples at cnt==CLKS_PER_BIT-1.
  - Adds output `parity_err` (1 bit, reset 0). It pulses in the STOP-exit cycle when ^{shift,parity_bit}!=0.
  - On parity error, data is not updated and valid stays 0.
  - If frame and parity errors coincide, both flags pulse.
- Undefined:
  - 8N1 framing; no PARITY state.
  - Port `parity_err` is absent.

Decomposition:
- Package `uart_pkg` holds:
  - typedef enum logic [2:0] state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam DATA_BITS=8;
  - localparam DEFAULT_CLKS_PER_BIT=32'h28B0 (shared with `send`).
- One sub-module: `sync2`, a 2-flop synchroniser with asynchronous active-low reset and reset value 1. It is reusable for PHYSICAL_BUTTON inputs.

Test Plan:
- Bench runs at CLKS_PER_BIT=16.
- Reset: hold RESET=0, toggle UART_RX -> data=00, valid=0, frame_err=0, busy=0 throughout.
- Single byte 8'hA5, stop bit=1 -> valid pulses once, data=A5, busy falls in the same cycle.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two valid pulses 160±1 cycles apart, data=00 then FF.
- Glitch: UART_RX low for 5 cycles, then high -> FSM returns to IDLE; no valid or frame_err.
- Stop bit low on byte 8'h3C -> frame_err pulses once, valid=0, data keeps its prior value.
- RESET pulsed low at bit 4 of 8'h81, then a clean 8'h42 sent after a 20-bit idle gap -> no strobe for the aborted frame; data=42.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 0 -> parity_err pulses, valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for send/receive
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;

  // 100 MHz / 9600 baud; the transmitter uses the same value
  localparam logic [31:0] DEFAULT_CLKS_PER_BIT = 32'h28B0;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for asynchronous inputs, resets to 1
module sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  // Reset high so an idle-high line never looks like a start edge
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receive.sv
// rtl/receive.sv - UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), LSB first
module receive
  import uart_pkg::*;
#(
  parameter logic [31:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam logic [31:0] HALF_M1 = CLKS_PER_BIT / 32'd2 - 32'd1;
  localparam logic [31:0] FULL_M1 = CLKS_PER_BIT - 32'd1;

  state_t               state;
  logic [31:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;

  sync2 u_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .d    (UART_RX),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_bad;

  // Even parity: data bits plus parity bit must XOR to zero
  always_comb begin
    parity_bad = ^{shift, parity_bit};
  end
`endif

  // Frame FSM: centre-samples each bit and emits one-cycle strobes on exit from STOP
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Start bit gone at its centre: treat as a glitch, silently
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_M1) begin
            // Leave at the stop-bit centre so half a bit remains to see the next start
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= parity_bad;
            if (rx_s && !parity_bad) begin
              data  <= shift;
              valid <= 1'b1;
            end
`else
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
